display_shift_driver: RTL and testbench

Converts the current time (hours, minutes, seconds) into six 7‑segment digit patterns and shifts them out to the off‑chip display shift‑register chain. It generates the serial data, shift clock and latch signals. Sits inside `clock_wrapper` directly downstream of the timekeeping counters; its three serial outputs drive `uo_out[0..2]`.

---
 rtl/display_shift_driver_if.sv | 24 ++
 rtl/display_shift_driver.sv | 162 ++++++++++++++++
 tb/tb_display_shift_driver.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_shift_driver_if.sv
// Bus between the timekeeping logic and the display shift driver:
// time/write inputs in, serial shift-register chain signals out.
interface display_shift_driver_if;
  logic       i_en;
  logic [4:0] i_hours;
  logic [5:0] i_minutes;
  logic [5:0] i_seconds;
  logic       i_colon;
  logic       i_write;
  logic       o_serial_data;
  logic       o_serial_clk;
  logic       o_serial_latch;
  logic       o_busy;

  modport master (
    output i_en, i_hours, i_minutes, i_seconds, i_colon, i_write,
    input  o_serial_data, o_serial_clk, o_serial_latch, o_busy
  );

  modport slave (
    input  i_en, i_hours, i_minutes, i_seconds, i_colon, i_write,
    output o_serial_data, o_serial_clk, o_serial_latch, o_busy
  );
endinterface

// File: rtl/display_shift_driver.sv
// Serialises HH:MM:SS as six 7-segment bytes (MSB first) into an off-chip
// shift-register chain, then pulses the storage latch.
module display_shift_driver #(
  parameter int unsigned SYS_CLK_HZ   = 5_000_000,
  parameter int unsigned SHIFT_CLK_HZ = 1_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  display_shift_driver_if.slave  bus
);

  localparam int unsigned DIV     = SYS_CLK_HZ / SHIFT_CLK_HZ;
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(DIV - DIV / 2);
  localparam logic [5:0]    BIT_LAST = 6'd47;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [5:0]    bit_q, bit_d;
  logic [47:0]   shreg_q, shreg_d;
  logic          pending_q, pending_d;

  logic [4:0]    hold_hours;
  logic [5:0]    hold_minutes;
  logic [5:0]    hold_seconds;
  logic          hold_colon;

  logic          data_q, data_d;
  logic          sclk_q, sclk_d;
  logic          latch_q, latch_d;
  logic          busy_q, busy_d;

  logic [3:0]    h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
  logic [7:0]    dp;
  logic [47:0]   frame;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    h_tens = 4'(hold_hours / 5'd10);
    h_ones = 4'(hold_hours % 5'd10);
    m_tens = 4'(hold_minutes / 6'd10);
    m_ones = 4'(hold_minutes % 6'd10);
    s_tens = 4'(hold_seconds / 6'd10);
    s_ones = 4'(hold_seconds % 6'd10);
    dp     = {hold_colon, 7'b0};
    frame  = {seg7(h_tens), seg7(h_ones) | dp,
              seg7(m_tens), seg7(m_ones) | dp,
              seg7(s_tens), seg7(s_ones)};
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    pending_d = pending_q;

    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d   = SHIFT;
          shreg_d   = frame;
          phase_d   = '0;
          bit_d     = '0;
          pending_d = 1'b0;
        end
      end
      SHIFT: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q + 6'd1;
            shreg_d = {shreg_q[46:0], 1'b0};
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      LATCH: begin
        if (phase_q == PH_LAST) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A write always leaves a request behind, even in the cycle a frame starts.
    if (bus.i_write) pending_d = 1'b1;

    // Outputs are decoded from next-state values so they can be registered
    // without adding a cycle of latency.
    data_d  = (state_d == SHIFT) & shreg_d[47];
    sclk_d  = (state_d == SHIFT) && (phase_d >= PH_RISE);
    latch_d = (state_d == LATCH);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      pending_q    <= 1'b0;
      hold_hours   <= '0;
      hold_minutes <= '0;
      hold_seconds <= '0;
      hold_colon   <= 1'b0;
      data_q       <= 1'b0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else if (bus.i_en) begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      if (bus.i_write) begin
        hold_hours   <= bus.i_hours;
        hold_minutes <= bus.i_minutes;
        hold_seconds <= bus.i_seconds;
        hold_colon   <= bus.i_colon;
      end
    end
  end

  assign bus.o_serial_data  = data_q;
  assign bus.o_serial_clk   = sclk_q;
  assign bus.o_serial_latch = latch_q;
  assign bus.o_busy         = busy_q;

endmodule

// File: tb/tb_display_shift_driver.sv
module tb_display_shift_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  display_shift_driver_if bus ();

  display_shift_driver #(
    .SYS_CLK_HZ  (5_000_000),
    .SHIFT_CLK_HZ(1_000_000)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  seg_tab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [47:0] exp_q [$];

  function automatic logic [47:0] frame_of(input int h, input int m,
                                           input int s, input logic c);
    logic [7:0] dpv;
    dpv = {c, 7'b0};
    return {seg_tab[4'(h / 10)], seg_tab[4'(h % 10)] | dpv,
            seg_tab[4'(m / 10)], seg_tab[4'(m % 10)] | dpv,
            seg_tab[4'(s / 10)], seg_tab[4'(s % 10)]};
  endfunction

  int          bits = 0;
  logic [47:0] cap = '0;
  int          since_rise = 0, since_change = 0, low_cnt = 0, high_cnt = 0;
  int          latch_w = 0, busy_en = 0, busy_raw = 0, last_busy_raw = 0;
  int          frames = 0;
  logic        p_sclk = 0, p_data = 0, p_latch = 0, p_busy = 0;

  always begin
    logic chg;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      bits = 0; cap = '0; since_rise = 0; since_change = 0;
      low_cnt = 0; high_cnt = 0; latch_w = 0; busy_en = 0; busy_raw = 0;
      p_sclk = 0; p_data = 0; p_latch = 0; p_busy = 0;
    end else begin
      if (bus.o_busy) busy_raw++;
      if (bus.i_en) begin
        since_rise++;
        since_change++;
        if (bus.o_busy) busy_en++;
        chg = (bus.o_serial_data !== p_data);
        if (chg) since_change = 0;
        if (bus.o_serial_clk && !p_sclk) begin
          if (bits > 0) begin
            n_assert++;
            if (since_rise !== 5) begin
              n_fail++;
              $error("FAIL sclk_period: observed %0d expected 5", since_rise);
            end
            n_assert++;
            if (low_cnt !== 3) begin
              n_fail++;
              $error("FAIL sclk_low_width: observed %0d expected 3", low_cnt);
            end
          end
          n_assert++;
          if (since_change < 2) begin
            n_fail++;
            $error("FAIL data_setup: observed %0d expected >=2", since_change);
          end
          cap = {cap[46:0], bus.o_serial_data};
          bits++;
          since_rise = 0;
          high_cnt = 0;
        end
        if (!bus.o_serial_clk && p_sclk) begin
          n_assert++;
          if (high_cnt !== 2) begin
            n_fail++;
            $error("FAIL sclk_high_width: observed %0d expected 2", high_cnt);
          end
          low_cnt = 0;
        end
        if (bus.o_serial_clk) high_cnt++; else low_cnt++;
        if (chg && bits > 0 && !bus.o_serial_latch) begin
          n_assert++;
          if (since_rise < 2) begin
            n_fail++;
            $error("FAIL data_hold: observed %0d expected >=2", since_rise);
          end
        end
        if (bus.o_serial_latch && !p_latch) begin
          frames++;
          n_assert++;
          if (bits !== 48) begin
            n_fail++;
            $error("FAIL bit_count: observed %0d expected 48", bits);
          end
          n_assert++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL frame_expected: no expected frame queued");
          end
          if (exp_q.size() > 0) begin
            logic [47:0] e;
            e = exp_q.pop_front();
            n_assert++;
            if (cap !== e) begin
              n_fail++;
              $error("FAIL frame_data: observed %0h expected %0h", cap, e);
            end
          end
          bits = 0;
          latch_w = 0;
        end
        if (bus.o_serial_latch) begin
          latch_w++;
          n_assert++;
          if (bus.o_serial_clk !== 1'b0) begin
            n_fail++;
            $error("FAIL latch_sclk_low: observed %0b expected 0", bus.o_serial_clk);
          end
        end
        if (!bus.o_serial_latch && p_latch) begin
          n_assert++;
          if (latch_w !== 5) begin
            n_fail++;
            $error("FAIL latch_width: observed %0d expected 5", latch_w);
          end
        end
        if (!bus.o_busy && p_busy) begin
          n_assert++;
          if (busy_en !== 245) begin
            n_fail++;
            $error("FAIL busy_length: observed %0d expected 245", busy_en);
          end
          last_busy_raw = busy_raw;
          busy_en = 0;
          busy_raw = 0;
        end
        p_sclk = bus.o_serial_clk; p_data = bus.o_serial_data;
        p_latch = bus.o_serial_latch; p_busy = bus.o_busy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_write(input int h, input int m, input int s, input logic c);
    @(negedge clk);
    bus.i_hours   = 5'(h);
    bus.i_minutes = 6'(m);
    bus.i_seconds = 6'(s);
    bus.i_colon   = c;
    bus.i_write   = 1'b1;
    @(negedge clk);
    bus.i_write   = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input int budget, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_busy === level) got = 1'b1;
    end
    n_assert++;
    if (got !== 1'b1) begin
      n_fail++;
      $error("FAIL %s: o_busy never reached %0b", tag, level);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  initial begin
    logic       seen;
    logic [3:0] snap;
    int         frames_before;
    int         rh, rm, rs;
    logic       rc;

    bus.i_en = 1'b1; bus.i_hours = '0; bus.i_minutes = '0;
    bus.i_seconds = '0; bus.i_colon = 1'b0; bus.i_write = 1'b0;

    repeat (3) @(negedge clk);
    chk_bit("rst_data", bus.o_serial_data, 1'b0);
    chk_bit("rst_sclk", bus.o_serial_clk, 1'b0);
    chk_bit("rst_latch", bus.o_serial_latch, 1'b0);
    chk_bit("rst_busy", bus.o_busy, 1'b0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.o_busy || bus.o_serial_data || bus.o_serial_clk || bus.o_serial_latch)
        seen = 1'b1;
    end
    chk_bit("idle_quiet", seen, 1'b0);

    exp_q.push_back(48'h06DB4FE66D7D);
    do_write(12, 34, 56, 1'b1);
    chk_bit("edge0_busy", bus.o_busy, 1'b0);
    @(posedge clk); #1;
    chk_bit("edge1_busy", bus.o_busy, 1'b1);
    chk_bit("edge1_data", bus.o_serial_data, 1'b0);
    chk_bit("edge1_sclk", bus.o_serial_clk, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_bit("edge3_sclk", bus.o_serial_clk, 1'b0);
    @(posedge clk); #1;
    chk_bit("edge4_sclk", bus.o_serial_clk, 1'b1);
    wait_busy(1'b0, 400, "basic_done");

    exp_q.push_back(48'h3F3F3F3F3F3F);
    exp_q.push_back(48'h5B4F6D6F6D6F);
    do_write(0, 0, 0, 1'b0);
    wait_busy(1'b1, 10, "f1_start");
    repeat (100) @(negedge clk);
    do_write(23, 59, 59, 1'b0);
    wait_busy(1'b0, 400, "f1_done");
    @(posedge clk); #1;
    chk_bit("f2_restart_gap", bus.o_busy, 1'b1);
    wait_busy(1'b0, 400, "f2_done");
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.o_busy) seen = 1'b1;
    end
    chk_bit("no_third_frame", seen, 1'b0);

    exp_q.push_back(frame_of(9, 7, 8, 1'b1));
    do_write(9, 7, 8, 1'b1);
    wait_busy(1'b1, 10, "en_start");
    repeat (60) @(negedge clk);
    bus.i_en = 1'b0;
    snap = {bus.o_serial_data, bus.o_serial_clk, bus.o_serial_latch, bus.o_busy};
    repeat (10) @(negedge clk);
    n_assert++;
    if ({bus.o_serial_data, bus.o_serial_clk, bus.o_serial_latch, bus.o_busy} !== snap) begin
      n_fail++;
      $error("FAIL en_hold_outputs: observed %0h expected %0h",
             {bus.o_serial_data, bus.o_serial_clk, bus.o_serial_latch, bus.o_busy}, snap);
    end
    bus.i_en = 1'b1;
    wait_busy(1'b0, 400, "en_done");
    @(negedge clk);
    n_assert++;
    if (last_busy_raw !== 255) begin
      n_fail++;
      $error("FAIL en_stretched_busy: observed %0d expected 255", last_busy_raw);
    end

    frames_before = frames;
    do_write(1, 2, 3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      if (bits == 20) seen = 1'b1;
    end
    chk_bit("reach_bit20", seen, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("midrst_data", bus.o_serial_data, 1'b0);
    chk_bit("midrst_sclk", bus.o_serial_clk, 1'b0);
    chk_bit("midrst_latch", bus.o_serial_latch, 1'b0);
    chk_bit("midrst_busy", bus.o_busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.o_busy || bus.o_serial_latch) seen = 1'b1;
    end
    chk_bit("post_reset_idle", seen, 1'b0);
    n_assert++;
    if (frames !== frames_before) begin
      n_fail++;
      $error("FAIL no_partial_latch: observed %0d expected %0d", frames, frames_before);
    end

    exp_q.push_back(48'h4F067D4F7D4F);
    do_write(31, 63, 63, 1'b0);
    wait_busy(1'b1, 10, "oor_start");
    wait_busy(1'b0, 400, "oor_done");

    rh = int'($urandom_range(0, 31));
    rm = int'($urandom_range(0, 63));
    rs = int'($urandom_range(0, 63));
    rc = 1'($urandom_range(0, 1));
    exp_q.push_back(frame_of(rh, rm, rs, rc));
    do_write(rh, rm, rs, rc);
    wait_busy(1'b1, 10, "rnd_start");
    wait_busy(1'b0, 400, "rnd_done");

    repeat (20) @(negedge clk);
    n_assert++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $error("FAIL queue_drained: observed %0d expected 0", exp_q.size());
    end
    n_assert++;
    if (frames !== 6) begin
      n_fail++;
      $error("FAIL frame_total: observed %0d expected 6", frames);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
